// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller: arbitrates entry/exit requests, raises the gate,
// tracks occupancy with saturation and reports vehicles that never cross.
module parking_gate_ctrl #(
  parameter int CAPACITY    = 100,
  parameter int OPEN_TICKS  = 8,
  parameter int GUARD_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        entry_req,
  input  logic        exit_req,
  input  logic        car_passed,
  output logic        gate_open,
  output logic        grant_entry,
  output logic        grant_exit,
  output logic [12:0] occupancy,
  output logic        full,
  output logic        timeout_err
);

  localparam logic [12:0] CAP_W   = 13'(CAPACITY);
  localparam logic [7:0]  OPEN_W  = 8'(OPEN_TICKS);
  localparam logic [3:0]  GUARD_W = 4'(GUARD_TICKS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OPEN_ENTRY = 2'd1,
    OPEN_EXIT  = 2'd2,
    CLOSING    = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  timer, timer_nxt;
  logic [3:0]  guard, guard_nxt;
  logic [12:0] occ_nxt;
  logic        timeout_nxt;
  logic        last_exit, last_exit_nxt;
  logic        entry_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // last_exit = 1 means exit was served most recently, so entry wins the next tie
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    guard_nxt     = guard;
    occ_nxt       = occupancy;
    timeout_nxt   = 1'b0;
    last_exit_nxt = last_exit;
    entry_ok      = entry_req && !full;
    case (state)
      IDLE: begin
        timer_nxt = 8'd0;
        guard_nxt = 4'd0;
        if (entry_ok && (!exit_req || last_exit)) begin
          state_nxt     = OPEN_ENTRY;
          timer_nxt     = 8'd1;
          last_exit_nxt = 1'b0;
        end else if (exit_req) begin
          state_nxt     = OPEN_EXIT;
          timer_nxt     = 8'd1;
          last_exit_nxt = 1'b1;
        end
      end
      OPEN_ENTRY, OPEN_EXIT: begin
        if (car_passed) begin
          state_nxt = CLOSING;
          timer_nxt = 8'd0;
          guard_nxt = 4'd1;
          if (state == OPEN_ENTRY && occupancy != CAP_W) occ_nxt = occupancy + 13'd1;
          if (state == OPEN_EXIT && occupancy != 13'd0)  occ_nxt = occupancy - 13'd1;
        end else if (timer == OPEN_W) begin
          state_nxt   = CLOSING;
          timer_nxt   = 8'd0;
          guard_nxt   = 4'd1;
          timeout_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      CLOSING: begin
        if (guard == GUARD_W) begin
          state_nxt = IDLE;
          guard_nxt = 4'd0;
        end else begin
          guard_nxt = guard + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = 8'd0;
        guard_nxt = 4'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer       <= 8'd0;
      guard       <= 4'd0;
      occupancy   <= 13'd0;
      full        <= 1'b0;
      timeout_err <= 1'b0;
      last_exit   <= 1'b1;
      gate_open   <= 1'b0;
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
    end else begin
      timer       <= timer_nxt;
      guard       <= guard_nxt;
      occupancy   <= occ_nxt;
      full        <= (occ_nxt == CAP_W);
      timeout_err <= timeout_nxt;
      last_exit   <= last_exit_nxt;
      gate_open   <= (state_nxt == OPEN_ENTRY) || (state_nxt == OPEN_EXIT);
      grant_entry <= (state_nxt == OPEN_ENTRY);
      grant_exit  <= (state_nxt == OPEN_EXIT);
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Randomised and directed bench for parking_gate_ctrl, checked every cycle
// against a phase-level model of the gate.
module tb_parking_gate_ctrl;

  localparam int CAP = 6;
  localparam int OT  = 8;
  localparam int GT  = 2;

  logic        clk = 1'b0;
  logic        reset, entry_req, exit_req, car_passed;
  logic        gate_open, grant_entry, grant_exit, full, timeout_err;
  logic [12:0] occupancy;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 serving entry, 2 serving exit, 3 closing
  int m_phase, m_cnt, m_occ;
  bit m_last_exit, m_timeout;

  int gate_cnt, to_cnt;
  bit got_entry, got_exit;

  parking_gate_ctrl #(.CAPACITY(CAP), .OPEN_TICKS(OT), .GUARD_TICKS(GT)) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .car_passed(car_passed), .gate_open(gate_open), .grant_entry(grant_entry),
    .grant_exit(grant_exit), .occupancy(occupancy), .full(full),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_occ = 0; m_last_exit = 1'b1; m_timeout = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit x, input bit p);
    int side;
    m_timeout = 1'b0;
    if (m_phase == 0) begin
      side = 0;
      if (e && m_occ != CAP && x) side = m_last_exit ? 1 : 2;
      else if (e && m_occ != CAP) side = 1;
      else if (x) side = 2;
      if (side != 0) begin
        m_phase = side; m_cnt = 1; m_last_exit = (side == 2);
      end
    end else if (m_phase == 3) begin
      if (m_cnt >= GT) m_phase = 0;
      else m_cnt++;
    end else if (p) begin
      if (m_phase == 1) m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
      else              m_occ = (m_occ > 0) ? m_occ - 1 : 0;
      m_phase = 3; m_cnt = 1;
    end else if (m_cnt >= OT) begin
      m_phase = 3; m_cnt = 1; m_timeout = 1'b1;
    end else begin
      m_cnt++;
    end
  endtask

  // Every cycle, away from the rising edge, the DUT must match the model
  always @(negedge clk) begin
    checkOutput("gate_open", gate_open, (m_phase == 1 || m_phase == 2));
    checkOutput("grant_entry", grant_entry, m_phase == 1);
    checkOutput("grant_exit", grant_exit, m_phase == 2);
    checkOutput("occupancy", occupancy, m_occ);
    checkOutput("full", full, m_occ == CAP);
    checkOutput("timeout_err", timeout_err, m_timeout);
    checkOutput("grant_exclusive", grant_entry & grant_exit, 0);
  end

  task automatic applyStimulus(input bit e, input bit x, input bit p);
    entry_req = e; exit_req = x; car_passed = p;
    @(posedge clk);
    model_step(e, x, p);
    @(negedge clk);
    car_passed = 1'b0;
  endtask

  // One full service from an idle cycle: pass_at = OPEN cycle carrying car_passed, 0 = never
  task automatic service(input bit e, input bit x, input int pass_at);
    int k, bound;
    gate_cnt = 0; to_cnt = 0;
    applyStimulus(e, x, 1'b0);
    got_entry = grant_entry; got_exit = grant_exit;
    gate_cnt += int'(gate_open);
    k = 1; bound = 0;
    while ((m_phase == 1 || m_phase == 2) && bound < 40) begin
      applyStimulus(e, x, k == pass_at);
      k++; bound++;
      gate_cnt += int'(gate_open); to_cnt += int'(timeout_err);
    end
    while (m_phase != 0 && bound < 40) begin
      applyStimulus(e, x, 1'b0);
      bound++;
      gate_cnt += int'(gate_open); to_cnt += int'(timeout_err);
    end
    if (bound >= 40) checkOutput("service_bound", bound, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got time %0t expected < 500000", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    model_reset();
    reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; car_passed = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_gate", gate_open, 0);
    checkOutput("rst_grants", {grant_entry, grant_exit}, 0);
    checkOutput("rst_occ", occupancy, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_timeout", timeout_err, 0);

    service(1'b1, 1'b0, 3);
    checkOutput("flow_grant", got_entry, 1);
    checkOutput("flow_gate_cycles", gate_cnt, 3);
    checkOutput("flow_occ", occupancy, 1);

    repeat (5) service(1'b1, 1'b0, 2);
    checkOutput("fill_occ", occupancy, 6);
    checkOutput("fill_full", full, 1);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("full_no_grant", grant_entry, 0);
    checkOutput("full_gate", gate_open, 0);
    service(1'b0, 1'b1, 1);
    checkOutput("exit_grant", got_exit, 1);
    checkOutput("exit_occ", occupancy, 5);
    checkOutput("exit_full", full, 0);

    service(1'b1, 1'b1, 2);
    checkOutput("tie1_entry", got_entry, 1);
    checkOutput("tie1_occ", occupancy, 6);
    service(1'b1, 1'b1, 2);
    checkOutput("tie2_exit", got_exit, 1);
    checkOutput("tie2_occ", occupancy, 5);
    service(1'b1, 1'b1, 2);
    checkOutput("tie3_entry", got_entry, 1);
    checkOutput("tie3_occ", occupancy, 6);

    service(1'b0, 1'b1, 1);
    service(1'b1, 1'b0, 0);
    checkOutput("to_gate_cycles", gate_cnt, 8);
    checkOutput("to_pulses", to_cnt, 1);
    checkOutput("to_occ", occupancy, 5);
    service(1'b1, 1'b0, 8);
    checkOutput("late_pass_pulses", to_cnt, 0);
    checkOutput("late_pass_occ", occupancy, 6);

    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pre_reset_exit", grant_exit, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_gate", gate_open, 0);
    checkOutput("async_grant_exit", grant_exit, 0);
    checkOutput("async_occ", occupancy, 0);
    checkOutput("async_full", full, 0);
    model_reset();
    entry_req = 1'b0; exit_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    service(1'b1, 1'b1, 1);
    checkOutput("post_reset_tie", got_entry, 1);
    checkOutput("post_reset_occ", occupancy, 1);
    service(1'b1, 1'b1, 1);
    checkOutput("post_reset_tie2", got_exit, 1);
    service(1'b0, 1'b1, 1);
    checkOutput("underflow_occ", occupancy, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle_pass_occ", occupancy, 0);
    checkOutput("idle_pass_gate", gate_open, 0);

    for (int seg = 0; seg < 3; seg++) begin
      int pe, px;
      pe = (seg == 0) ? 80 : (seg == 1) ? 15 : 50;
      px = (seg == 0) ? 15 : (seg == 1) ? 80 : 50;
      for (int i = 0; i < 300; i++) begin
        applyStimulus($urandom_range(0, 99) < pe, $urandom_range(0, 99) < px,
                      $urandom_range(0, 99) < 25);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
